// File: rtl/decode_stage_if.sv
// Fetch-to-execute handshake bundle for the decode stage: the fetch side presents
// inst/pc, the execute side receives the decoded head entry.
interface decode_stage_if #(
    parameter int PC_W = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [PC_W-1:0] in_pc;

    logic            out_valid;
    logic            out_ready;
    logic [PC_W-1:0] out_pc;
    logic [31:0]     out_imm;
    logic [4:0]      out_alu_op;
    logic [4:0]      out_mem_access;
    logic            out_rf_we;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [1:0]      out_alu_rs1_sel;
    logic [1:0]      out_alu_rs2_sel;
    logic            out_wb_rf_sel;
    logic [4:0]      out_br_type;
    logic            out_illegal;

    // master drives fetch inputs and execute-side ready; slave is the decode stage
    modport master (
        output in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_alu_op, out_mem_access,
               out_rf_we, out_rd, out_rs1, out_rs2, out_alu_rs1_sel, out_alu_rs2_sel,
               out_wb_rf_sel, out_br_type, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_alu_op, out_mem_access,
               out_rf_we, out_rd, out_rs1, out_rs2, out_alu_rs1_sel, out_alu_rs2_sel,
               out_wb_rf_sel, out_br_type, out_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I(+M) decode stage: combinational decode of the fetched word into a bundle,
// buffered in a DEPTH-entry FIFO with valid/ready on both sides and synchronous flush.
module decode_stage #(
    parameter int DEPTH    = 2,
    parameter int ENABLE_M = 0,
    parameter int PC_W     = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    decode_stage_if.slave bus,
    output logic [15:0]   illegal_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    localparam logic [1:0] SRC1_REG1 = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_REG2 = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic       FROM_ALU  = 1'b0;
    localparam logic       FROM_MEM  = 1'b1;
    localparam logic [4:0] NO_ACCESS = 5'd0;
    localparam logic [4:0] ALU_ADD   = 5'd0;

    localparam logic [6:0] OP_LUI    = 7'h37;
    localparam logic [6:0] OP_AUIPC  = 7'h17;
    localparam logic [6:0] OP_JAL    = 7'h6f;
    localparam logic [6:0] OP_JALR   = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63;
    localparam logic [6:0] OP_LOAD   = 7'h03;
    localparam logic [6:0] OP_STORE  = 7'h23;
    localparam logic [6:0] OP_IMM    = 7'h13;
    localparam logic [6:0] OP_REG    = 7'h33;

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     imm;
        logic [4:0]      alu_op;
        logic [4:0]      mem_access;
        logic            rf_we;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [1:0]      alu_rs1_sel;
        logic [1:0]      alu_rs2_sel;
        logic            wb_rf_sel;
        logic [4:0]      br_type;
        logic            illegal;
    } entry_t;

    logic [31:0] inst;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] imm_u;

    assign inst   = bus.in_inst;
    assign funct3 = inst[14:12];
    assign funct7 = inst[31:25];
    assign imm_i  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    assign imm_u  = {inst[31:12], 12'b0};

    entry_t dec_entry;
    logic   dec_writes;
    logic   dec_legal;

    always_comb begin
        dec_entry             = '0;
        dec_writes            = 1'b1;
        dec_legal             = 1'b1;
        dec_entry.pc          = bus.in_pc;
        dec_entry.rd          = inst[11:7];
        dec_entry.rs1         = inst[19:15];
        dec_entry.rs2         = inst[24:20];
        dec_entry.alu_op      = ALU_ADD;
        dec_entry.mem_access  = NO_ACCESS;
        dec_entry.alu_rs1_sel = SRC1_REG1;
        dec_entry.alu_rs2_sel = SRC2_REG2;
        dec_entry.wb_rf_sel   = FROM_ALU;
        dec_entry.br_type     = {1'b0, inst[2], funct3};

        case (inst[6:0])
            OP_LUI: begin
                dec_entry.imm         = imm_u;
                dec_entry.alu_rs1_sel = SRC1_ZERO;
                dec_entry.alu_rs2_sel = SRC2_IMM;
                dec_entry.br_type     = {2'b00, funct3};
            end
            OP_AUIPC: begin
                dec_entry.imm         = imm_u;
                dec_entry.alu_rs1_sel = SRC1_PC;
                dec_entry.alu_rs2_sel = SRC2_IMM;
                dec_entry.br_type     = {2'b00, funct3};
            end
            // jumps compute the link address pc+4; the target comes from imm
            OP_JAL: begin
                dec_entry.imm         = imm_j;
                dec_entry.alu_rs1_sel = SRC1_PC;
                dec_entry.alu_rs2_sel = SRC2_FOUR;
                dec_entry.br_type     = {1'b1, inst[2], inst[3], inst[1:0]};
            end
            OP_JALR: begin
                dec_entry.imm         = imm_i;
                dec_entry.alu_rs1_sel = SRC1_PC;
                dec_entry.alu_rs2_sel = SRC2_FOUR;
                dec_entry.br_type     = {1'b1, inst[2], inst[3], inst[1:0]};
            end
            OP_BRANCH: begin
                dec_entry.imm     = imm_b;
                dec_writes        = 1'b0;
                dec_entry.br_type = {1'b1, inst[2], funct3};
            end
            OP_LOAD: begin
                dec_entry.imm         = imm_i;
                dec_entry.mem_access  = {2'b01, funct3};
                dec_entry.alu_rs2_sel = SRC2_IMM;
                dec_entry.wb_rf_sel   = FROM_MEM;
            end
            OP_STORE: begin
                dec_entry.imm         = imm_s;
                dec_entry.mem_access  = {2'b10, funct3};
                dec_entry.alu_rs2_sel = SRC2_IMM;
                dec_writes            = 1'b0;
            end
            OP_IMM: begin
                dec_entry.imm         = imm_i;
                dec_entry.alu_rs2_sel = SRC2_IMM;
                dec_entry.alu_op      = {(funct3 == 3'd5) && inst[30], 1'b0, funct3};
            end
            OP_REG: begin
                if (funct7 == 7'h00 || funct7 == 7'h20) begin
                    dec_entry.alu_op = {inst[30], 1'b0, funct3};
                end else if (funct7 == 7'h01 && ENABLE_M != 0) begin
                    dec_entry.alu_op = {2'b01, funct3};
                end else begin
                    dec_legal = 1'b0;
                end
            end
            default: dec_legal = 1'b0;
        endcase

        dec_entry.rf_we = dec_writes && (inst[11:7] != 5'd0);

        // an illegal word keeps only its pc so execute can trap precisely
        if (!dec_legal) begin
            dec_entry         = '0;
            dec_entry.pc      = bus.in_pc;
            dec_entry.illegal = 1'b1;
        end
    end

    entry_t        mem_q [DEPTH];
    entry_t        head_q, head_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [15:0]   illegal_cnt_q, illegal_cnt_d;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    assign full  = (count_q == FULL_COUNT);
    assign empty = (count_q == '0);
    assign push  = bus.in_valid && !full && !flush;
    assign pop   = !empty && bus.out_ready && !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        head_d        = head_q;
        illegal_cnt_d = illegal_cnt_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end

        if (push && dec_entry.illegal && illegal_cnt_q != 16'hFFFF) begin
            illegal_cnt_d = illegal_cnt_q + 16'd1;
        end

        // head register tracks the next head; bypass when it is being written now,
        // and hold the last value once the FIFO drains
        if (count_d != '0) begin
            head_d = (push && wr_ptr_q == rd_ptr_d) ? dec_entry : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            head_q        <= '0;
            illegal_cnt_q <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            head_q        <= head_d;
            illegal_cnt_q <= illegal_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= dec_entry;
        end
    end

    assign bus.in_ready        = !full;
    assign bus.out_valid       = !empty;
    assign bus.out_pc          = head_q.pc;
    assign bus.out_imm         = head_q.imm;
    assign bus.out_alu_op      = head_q.alu_op;
    assign bus.out_mem_access  = head_q.mem_access;
    assign bus.out_rf_we       = head_q.rf_we;
    assign bus.out_rd          = head_q.rd;
    assign bus.out_rs1         = head_q.rs1;
    assign bus.out_rs2         = head_q.rs2;
    assign bus.out_alu_rs1_sel = head_q.alu_rs1_sel;
    assign bus.out_alu_rs2_sel = head_q.alu_rs2_sel;
    assign bus.out_wb_rf_sel   = head_q.wb_rf_sel;
    assign bus.out_br_type     = head_q.br_type;
    assign bus.out_illegal     = head_q.illegal;
    assign illegal_cnt         = illegal_cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: two instances (ENABLE_M=0 and 1) share stimulus; a queue model
// checks every cycle, plus a hand-computed decode table and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_decode_stage;
    localparam int DEPTH = 2;
    localparam int PC_W  = 32;

    localparam logic [1:0] SRC1_REG1 = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;
    localparam logic [1:0] SRC2_REG2 = 2'd0;
    localparam logic [1:0] SRC2_IMM  = 2'd1;
    localparam logic [1:0] SRC2_FOUR = 2'd2;
    localparam logic       FROM_MEM  = 1'b1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [4:0]  mem;
        logic        rf_we;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic        wb;
        logic [4:0]  br;
        logic        illegal;
    } bundle_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_t;

    typedef struct packed {
        logic [31:0] inst;
        logic        sel;
        logic [31:0] imm;
        logic [4:0]  alu;
        logic [1:0]  s1;
        logic [1:0]  s2;
        logic        rf_we;
        logic [4:0]  rd;
        logic [4:0]  br;
        logic        illegal;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [31:0] in_pc = '0;
    logic [15:0] cnt0, cnt1;

    always #5 clk = ~clk;

    decode_stage_if #(.PC_W(PC_W)) bus0 ();
    decode_stage_if #(.PC_W(PC_W)) bus1 ();

    assign bus0.in_valid  = in_valid;
    assign bus0.in_inst   = in_inst;
    assign bus0.in_pc     = in_pc;
    assign bus0.out_ready = out_ready;
    assign bus1.in_valid  = in_valid;
    assign bus1.in_inst   = in_inst;
    assign bus1.in_pc     = in_pc;
    assign bus1.out_ready = out_ready;

    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(0), .PC_W(PC_W)) dut0 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus0), .illegal_cnt(cnt0));
    decode_stage #(.DEPTH(DEPTH), .ENABLE_M(1), .PC_W(PC_W)) dut1 (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus1), .illegal_cnt(cnt1));

    bundle_t     got [2];
    logic        ov [2];
    logic        ir [2];
    logic [15:0] gcnt [2];

    assign got[0] = {bus0.out_pc, bus0.out_imm, bus0.out_alu_op, bus0.out_mem_access, bus0.out_rf_we,
                     bus0.out_rd, bus0.out_rs1, bus0.out_rs2, bus0.out_alu_rs1_sel, bus0.out_alu_rs2_sel,
                     bus0.out_wb_rf_sel, bus0.out_br_type, bus0.out_illegal};
    assign got[1] = {bus1.out_pc, bus1.out_imm, bus1.out_alu_op, bus1.out_mem_access, bus1.out_rf_we,
                     bus1.out_rd, bus1.out_rs1, bus1.out_rs2, bus1.out_alu_rs1_sel, bus1.out_alu_rs2_sel,
                     bus1.out_wb_rf_sel, bus1.out_br_type, bus1.out_illegal};
    assign ov[0] = bus0.out_valid;
    assign ov[1] = bus1.out_valid;
    assign ir[0] = bus0.in_ready;
    assign ir[1] = bus1.in_ready;
    assign gcnt[0] = cnt0;
    assign gcnt[1] = cnt1;

    int     n_checks = 0;
    int     n_fail = 0;
    fetch_t q [$];
    int     mcnt [2];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode built from the instruction-format rules with plain arithmetic.
    function automatic bundle_t ref_decode(input logic [31:0] i, input logic [31:0] pc, input int k);
        bundle_t     b;
        logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        logic [2:0]  f3;
        bit          writes, legal;
        imm_i = 32'($signed(i) >>> 20);
        imm_s = (32'($signed(i) >>> 25) << 5) | 32'(i[11:7]);
        imm_b = (32'($signed(i) >>> 31) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        imm_j = (32'($signed(i) >>> 31) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        imm_u = i & 32'hFFFF_F000;
        f3 = i[14:12];
        writes = 1'b1;
        legal = 1'b1;
        b = '0;
        b.pc = pc;
        b.rd = i[11:7];
        b.rs1 = i[19:15];
        b.rs2 = i[24:20];
        b.br = {1'b0, i[2], f3};
        case (i[6:0])
            7'h37: begin b.imm = imm_u; b.s1 = SRC1_ZERO; b.s2 = SRC2_IMM; b.br = {2'b00, f3}; end
            7'h17: begin b.imm = imm_u; b.s1 = SRC1_PC; b.s2 = SRC2_IMM; b.br = {2'b00, f3}; end
            7'h6f: begin b.imm = imm_j; b.s1 = SRC1_PC; b.s2 = SRC2_FOUR; b.br = {1'b1, i[2], i[3], i[1:0]}; end
            7'h67: begin b.imm = imm_i; b.s1 = SRC1_PC; b.s2 = SRC2_FOUR; b.br = {1'b1, i[2], i[3], i[1:0]}; end
            7'h63: begin b.imm = imm_b; writes = 1'b0; b.br = {1'b1, i[2], f3}; end
            7'h03: begin b.imm = imm_i; b.mem = {2'b01, f3}; b.s2 = SRC2_IMM; b.wb = FROM_MEM; end
            7'h23: begin b.imm = imm_s; b.mem = {2'b10, f3}; b.s2 = SRC2_IMM; writes = 1'b0; end
            7'h13: begin b.imm = imm_i; b.s2 = SRC2_IMM; b.alu = {(f3 == 3'd5) && i[30], 1'b0, f3}; end
            7'h33: begin
                if (i[31:25] == 7'h00 || i[31:25] == 7'h20) b.alu = {i[30], 1'b0, f3};
                else if (i[31:25] == 7'h01 && k == 1) b.alu = {2'b01, f3};
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        b.rf_we = writes && (i[11:7] != 5'd0);
        if (!legal) begin
            b = '0;
            b.pc = pc;
            b.illegal = 1'b1;
        end
        return b;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        int          pick;
        r = $urandom;
        pick = $urandom_range(0, 11);
        case (pick)
            0: r[6:0] = 7'h37;
            1: r[6:0] = 7'h17;
            2: r[6:0] = 7'h6f;
            3: r[6:0] = 7'h67;
            4: r[6:0] = 7'h63;
            5: r[6:0] = 7'h03;
            6: r[6:0] = 7'h23;
            7: r[6:0] = 7'h13;
            8, 9: begin
                r[6:0] = 7'h33;
                case ($urandom_range(0, 3))
                    0: r[31:25] = 7'h00;
                    1: r[31:25] = 7'h20;
                    2: r[31:25] = 7'h01;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return r;
    endfunction

    task automatic compare_model();
        bundle_t e;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("out_valid[%0d]", k), 128'(ov[k]), 128'(q.size() != 0));
            chk($sformatf("in_ready[%0d]", k), 128'(ir[k]), 128'(q.size() < DEPTH));
            chk($sformatf("illegal_cnt[%0d]", k), 128'(gcnt[k]), 128'(mcnt[k]));
            if (q.size() != 0) begin
                e = ref_decode(q[0].inst, q[0].pc, k);
                chk($sformatf("head[%0d] pc=%0h", k, q[0].pc), 128'(got[k]), 128'(e));
            end
        end
    endtask

    // Advance one clock: update the model with the inputs the DUT sees, then compare.
    task automatic tick();
        bit      push, pop;
        bundle_t e;
        fetch_t  f;
        push = in_valid && (q.size() < DEPTH) && !flush;
        pop  = (q.size() > 0) && out_ready && !flush;
        if (rst) begin
            q.delete();
            mcnt[0] = 0;
            mcnt[1] = 0;
        end else if (flush) begin
            q.delete();
        end else begin
            if (push) begin
                for (int k = 0; k < 2; k++) begin
                    e = ref_decode(in_inst, in_pc, k);
                    if (e.illegal && mcnt[k] < 16'hFFFF) mcnt[k]++;
                end
            end
            if (pop) void'(q.pop_front());
            if (push) begin
                f.inst = in_inst;
                f.pc = in_pc;
                q.push_back(f);
            end
        end
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    vec_t vecs [13];

    initial begin
        mcnt[0] = 0;
        mcnt[1] = 0;
        vecs[0]  = '{32'h123452B7, 1'b0, 32'h12345000, 5'd0,  SRC1_ZERO, SRC2_IMM,  1'b1, 5'd5, 5'd5,  1'b0};
        vecs[1]  = '{32'h00001097, 1'b0, 32'h00001000, 5'd0,  SRC1_PC,   SRC2_IMM,  1'b1, 5'd1, 5'd1,  1'b0};
        vecs[2]  = '{32'h004100E7, 1'b0, 32'h00000004, 5'd0,  SRC1_PC,   SRC2_FOUR, 1'b1, 5'd1, 5'h1B, 1'b0};
        vecs[3]  = '{32'h402081B3, 1'b0, 32'h00000000, 5'h10, SRC1_REG1, SRC2_REG2, 1'b1, 5'd3, 5'd0,  1'b0};
        vecs[4]  = '{32'h022081B3, 1'b1, 32'h00000000, 5'h08, SRC1_REG1, SRC2_REG2, 1'b1, 5'd3, 5'd0,  1'b0};
        vecs[5]  = '{32'h022081B3, 1'b0, 32'h00000000, 5'd0,  2'd0,      2'd0,      1'b0, 5'd0, 5'd0,  1'b1};
        vecs[6]  = '{32'h00000000, 1'b0, 32'h00000000, 5'd0,  2'd0,      2'd0,      1'b0, 5'd0, 5'd0,  1'b1};
        vecs[7]  = '{32'hFFF00093, 1'b0, 32'hFFFFFFFF, 5'd0,  SRC1_REG1, SRC2_IMM,  1'b1, 5'd1, 5'd0,  1'b0};
        vecs[8]  = '{32'h00001037, 1'b1, 32'h00001000, 5'd0,  SRC1_ZERO, SRC2_IMM,  1'b0, 5'd0, 5'd1,  1'b0};
        vecs[9]  = '{32'h4030D113, 1'b0, 32'h00000403, 5'h15, SRC1_REG1, SRC2_IMM,  1'b1, 5'd2, 5'd5,  1'b0};
        vecs[10] = '{32'hFFFFFFFF, 1'b1, 32'h00000000, 5'd0,  2'd0,      2'd0,      1'b0, 5'd0, 5'd0,  1'b1};
        vecs[11] = '{32'h042081B3, 1'b1, 32'h00000000, 5'd0,  2'd0,      2'd0,      1'b0, 5'd0, 5'd0,  1'b1};
        vecs[12] = '{32'h00000000, 1'b1, 32'h00000000, 5'd0,  2'd0,      2'd0,      1'b0, 5'd0, 5'd0,  1'b1};

        // reset state: all bundle fields zero, empty, ready
        do_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("reset bundle[%0d]", k), 128'(got[k]), 128'(0));
            chk($sformatf("reset in_ready[%0d]", k), 128'(ir[k]), 128'(1));
        end

        // decode table: each row pushed into an empty FIFO after reset
        for (int v = 0; v < 13; v++) begin
            int s;
            s = int'(vecs[v].sel);
            do_reset();
            out_ready = 1'b0;
            in_valid = 1'b1;
            in_inst = vecs[v].inst;
            in_pc = 32'(v * 4);
            tick();
            in_valid = 1'b0;
            $display("vec %0d inst=%08h dut%0d imm=%08h alu=%02h ill=%0d", v, vecs[v].inst, s,
                     got[s].imm, got[s].alu, got[s].illegal);
            chk($sformatf("vec%0d valid", v), 128'(ov[s]), 128'(1));
            chk($sformatf("vec%0d imm", v), 128'(got[s].imm), 128'(vecs[v].imm));
            chk($sformatf("vec%0d alu_op", v), 128'(got[s].alu), 128'(vecs[v].alu));
            chk($sformatf("vec%0d rs1_sel", v), 128'(got[s].s1), 128'(vecs[v].s1));
            chk($sformatf("vec%0d rs2_sel", v), 128'(got[s].s2), 128'(vecs[v].s2));
            chk($sformatf("vec%0d rf_we", v), 128'(got[s].rf_we), 128'(vecs[v].rf_we));
            chk($sformatf("vec%0d rd", v), 128'(got[s].rd), 128'(vecs[v].rd));
            chk($sformatf("vec%0d br_type", v), 128'(got[s].br), 128'(vecs[v].br));
            chk($sformatf("vec%0d illegal", v), 128'(got[s].illegal), 128'(vecs[v].illegal));
            chk($sformatf("vec%0d illegal_cnt", v), 128'(gcnt[s]), 128'(vecs[v].illegal));
        end

        // randomized traffic against the queue model
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            rst       = ($urandom_range(0, 299) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            tick();
            if (c % 100 == 0) $display("random cycle %0d occupancy=%0d illegal_cnt=%0d/%0d", c, q.size(), cnt0, cnt1);
        end
        rst = 1'b0;
        flush = 1'b0;

        // backpressure: fill, hold the third, drain in order
        do_reset();
        out_ready = 1'b0;
        in_inst = 32'h00000013;
        in_valid = 1'b1;
        in_pc = 32'd0;
        tick();
        chk("bp in_ready after 1st", 128'(ir[0]), 128'(1));
        in_pc = 32'd4;
        tick();
        chk("bp in_ready after 2nd", 128'(ir[0]), 128'(0));
        in_pc = 32'd8;
        tick();
        chk("bp held head pc", 128'(got[0].pc), 128'(0));
        chk("bp still full", 128'(ir[0]), 128'(0));
        out_ready = 1'b1;
        tick();
        chk("bp drain pc4", 128'(got[0].pc), 128'(4));
        tick();
        chk("bp drain pc8", 128'(got[0].pc), 128'(8));
        in_valid = 1'b0;
        tick();
        chk("bp drained", 128'(ov[0]), 128'(0));
        $display("backpressure sequence done");

        // streaming: one in, one out per cycle, latency 1
        do_reset();
        out_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            in_valid = 1'b1;
            in_pc = 32'(s * 4);
            in_inst = rand_inst();
            tick();
            chk($sformatf("stream%0d valid", s), 128'(ov[0]), 128'(1));
            chk($sformatf("stream%0d pc", s), 128'(got[0].pc), 128'(s * 4));
            chk($sformatf("stream%0d in_ready", s), 128'(ir[0]), 128'(1));
        end
        in_valid = 1'b0;
        tick();
        chk("stream end valid", 128'(ov[0]), 128'(0));

        // flush while full with an incoming illegal word
        do_reset();
        out_ready = 1'b0;
        in_inst = 32'h00000000;
        in_valid = 1'b1;
        tick();
        tick();
        chk("flush pre full", 128'(ir[0]), 128'(0));
        flush = 1'b1;
        in_pc = 32'h40;
        tick();
        chk("flush out_valid", 128'(ov[0]), 128'(0));
        chk("flush in_ready", 128'(ir[0]), 128'(1));
        chk("flush keeps illegal_cnt", 128'(cnt0), 128'(2));
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk("flush nothing pushed", 128'(ov[0]), 128'(0));
        $display("flush sequence done");

        // reset mid-stream with two entries held
        do_reset();
        out_ready = 1'b0;
        in_inst = 32'h00000000;
        in_valid = 1'b1;
        tick();
        tick();
        chk("rst pre cnt", 128'(cnt0), 128'(2));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("rst out_valid", 128'(ov[0]), 128'(0));
        chk("rst illegal_cnt", 128'(cnt0), 128'(0));
        chk("rst bundle zero", 128'(got[0]), 128'(0));
        chk("rst in_ready", 128'(ir[0]), 128'(1));
        $display("reset sequence done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
